// File: rtl/ahb3_pkg.sv
// Shared AHB3 encodings and the boot copier state type.
// Latency: n/a (declarations only). Backpressure: n/a.
package ahb3_pkg;

  localparam logic [1:0] HTRANS_IDLE     = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ   = 2'b10;
  localparam logic [2:0] HBURST_SINGLE   = 3'b000;
  localparam logic [2:0] HSIZE_WORD      = 3'b010;
  localparam logic [2:0] HSIZE_DWORD     = 3'b011;
  localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;
  localparam logic       HRESP_OKAY      = 1'b0;
  localparam logic       HRESP_ERROR     = 1'b1;

  typedef enum logic [2:0] {
    CP_IDLE,
    CP_RD_A,
    CP_RD_D,
    CP_WR_A,
    CP_WR_D,
    CP_ERR,
    CP_DONE
  } copier_state_t;

endpackage

// File: rtl/ahb3_boot_copier.sv
// Boot-time block copier: AHB3 single-transfer initiator, one read then one write per word.
// Latency: 4 cycles per word with zero wait states, start to done = 4*len+1 cycles.
// Backpressure: every phase stalls on hready_i=0; start_i is ignored unless idle.
module ahb3_boot_copier
  import ahb3_pkg::*;
#(
  parameter int PLEN  = 32,
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [PLEN-1:0]  src_addr_i,
  input  logic [PLEN-1:0]  dst_addr_i,
  input  logic [CNT_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [PLEN-1:0]  ahb3_haddr_o,
  output logic [XLEN-1:0]  ahb3_hwdata_o,
  input  logic [XLEN-1:0]  ahb3_hrdata_i,
  output logic             ahb3_hwrite_o,
  output logic [2:0]       ahb3_hsize_o,
  output logic [2:0]       ahb3_hburst_o,
  output logic [3:0]       ahb3_hprot_o,
  output logic [1:0]       ahb3_htrans_o,
  output logic             ahb3_hmastlock_o,
  input  logic             ahb3_hready_i,
  input  logic             ahb3_hresp_i
);

  localparam int              AB   = $clog2(XLEN / 8);
  localparam logic [PLEN-1:0] STEP = PLEN'(XLEN / 8);

  copier_state_t    state;
  logic [PLEN-1:0]  src_q;
  logic [PLEN-1:0]  dst_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_nxt;
  logic [PLEN-1:0]  src_nxt;

  function automatic logic [PLEN-1:0] align(input logic [PLEN-1:0] a);
    align = {a[PLEN-1:AB], {AB{1'b0}}};
  endfunction

  assign count_nxt = count_q + 1'b1;
  assign src_nxt   = src_q + STEP;

  assign ahb3_hsize_o     = (XLEN == 64) ? HSIZE_DWORD : HSIZE_WORD;
  assign ahb3_hburst_o    = HBURST_SINGLE;
  assign ahb3_hprot_o     = HPROT_DATA_PRIV;
  assign ahb3_hmastlock_o = 1'b0;

  // ahb3_hwdata_o doubles as the data register: loaded at the end of the read
  // data phase and left untouched until the next read completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= CP_IDLE;
      src_q         <= '0;
      dst_q         <= '0;
      len_q         <= '0;
      count_q       <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
      ahb3_haddr_o  <= '0;
      ahb3_hwdata_o <= '0;
      ahb3_hwrite_o <= 1'b0;
      ahb3_htrans_o <= HTRANS_IDLE;
    end else begin
      case (state)
        CP_IDLE: begin
          if (start_i) begin
            src_q   <= align(src_addr_i);
            dst_q   <= align(dst_addr_i);
            len_q   <= len_i;
            count_q <= '0;
            err_o   <= 1'b0;
            busy_o  <= 1'b1;
            if (len_i == '0) begin
              state  <= CP_DONE;
              done_o <= 1'b1;
            end else begin
              state         <= CP_RD_A;
              ahb3_htrans_o <= HTRANS_NONSEQ;
              ahb3_haddr_o  <= align(src_addr_i);
              ahb3_hwrite_o <= 1'b0;
            end
          end
        end

        CP_RD_A: begin
          if (ahb3_hready_i) begin
            state         <= CP_RD_D;
            ahb3_htrans_o <= HTRANS_IDLE;
          end
        end

        CP_RD_D: begin
          if (ahb3_hready_i) begin
            if (ahb3_hresp_i == HRESP_ERROR) begin
              state <= CP_ERR;
            end else begin
              ahb3_hwdata_o <= ahb3_hrdata_i;
              state         <= CP_WR_A;
              ahb3_htrans_o <= HTRANS_NONSEQ;
              ahb3_haddr_o  <= dst_q;
              ahb3_hwrite_o <= 1'b1;
            end
          end
        end

        CP_WR_A: begin
          if (ahb3_hready_i) begin
            state         <= CP_WR_D;
            ahb3_htrans_o <= HTRANS_IDLE;
          end
        end

        CP_WR_D: begin
          if (ahb3_hready_i) begin
            if (ahb3_hresp_i == HRESP_OKAY) begin
              count_q <= count_nxt;
              src_q   <= src_nxt;
              dst_q   <= dst_q + STEP;
              if (count_nxt == len_q) begin
                state  <= CP_DONE;
                done_o <= 1'b1;
              end else begin
                state         <= CP_RD_A;
                ahb3_htrans_o <= HTRANS_NONSEQ;
                ahb3_haddr_o  <= src_nxt;
                ahb3_hwrite_o <= 1'b0;
              end
            end else begin
              state <= CP_ERR;
            end
          end
        end

        CP_ERR: begin
          err_o  <= 1'b1;
          state  <= CP_DONE;
          done_o <= 1'b1;
        end

        CP_DONE: begin
          done_o <= 1'b0;
          busy_o <= 1'b0;
          state  <= CP_IDLE;
        end

        default: begin
          state         <= CP_IDLE;
          busy_o        <= 1'b0;
          done_o        <= 1'b0;
          ahb3_htrans_o <= HTRANS_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb3_boot_copier.sv
// Bench for ahb3_boot_copier: reactive AHB3 slave with configurable waits/errors,
// vector table plus random copies checked against a word-level copy model.
module tb_ahb3_boot_copier;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [31:0] src_addr_i;
  logic [31:0] dst_addr_i;
  logic [15:0] len_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [31:0] ahb3_haddr_o;
  logic [31:0] ahb3_hwdata_o;
  logic [31:0] ahb3_hrdata_i;
  logic        ahb3_hwrite_o;
  logic [2:0]  ahb3_hsize_o;
  logic [2:0]  ahb3_hburst_o;
  logic [3:0]  ahb3_hprot_o;
  logic [1:0]  ahb3_htrans_o;
  logic        ahb3_hmastlock_o;
  logic        ahb3_hready_i;
  logic        ahb3_hresp_i;

  ahb3_boot_copier dut (
    .clk(clk), .rst(rst), .start_i(start_i),
    .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .ahb3_haddr_o(ahb3_haddr_o), .ahb3_hwdata_o(ahb3_hwdata_o),
    .ahb3_hrdata_i(ahb3_hrdata_i), .ahb3_hwrite_o(ahb3_hwrite_o),
    .ahb3_hsize_o(ahb3_hsize_o), .ahb3_hburst_o(ahb3_hburst_o),
    .ahb3_hprot_o(ahb3_hprot_o), .ahb3_htrans_o(ahb3_htrans_o),
    .ahb3_hmastlock_o(ahb3_hmastlock_o), .ahb3_hready_i(ahb3_hready_i),
    .ahb3_hresp_i(ahb3_hresp_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    int          len;
    int          aw;       // address-phase wait cycles
    int          dw;       // data-phase wait cycles
    int          ek;       // 0 none, 1 read error, 2 write error
    int          ew;       // word index that gets the error
    bit          mid;      // poke start while busy and in DONE
    int          exp_cyc;  // cycles from accepted start to done pulse
    bit          exp_err;
    int          exp_nwr;  // words that land in RAM
  } vec_t;

  int checks = 0;
  int errors = 0;

  int cfg_aw = 0, cfg_dw = 0, cfg_ek = 0, cfg_ew = 0;

  // slave-owned state
  logic [31:0] ram [logic [31:0]];
  logic [31:0] log_a [$];
  bit          log_w [$];
  int          stab_viol;
  bit          ap_on, dp_on, dp_first, dp_write, dp_err, ap_write, prev_busy;
  logic [31:0] ap_addr, dp_addr, dp_wd;
  int          ap_wait, dp_wait, rd_idx, wr_idx;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'hA0 + (a >> 2);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reactive AHB3 slave; decides hready/hresp/hrdata for the coming rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      ap_on = 0; dp_on = 0; prev_busy = 0;
      ahb3_hready_i = 1'b1; ahb3_hresp_i = 1'b0; ahb3_hrdata_i = '0;
    end else begin
      if (busy_o && !prev_busy) begin
        rd_idx = 0; wr_idx = 0; stab_viol = 0;
        log_a.delete(); log_w.delete(); ram.delete();
      end
      prev_busy = busy_o;
      if (dp_on) begin
        if (ahb3_htrans_o != 2'b00 || ahb3_haddr_o != dp_addr) stab_viol++;
        if (dp_write) begin
          if (dp_first) dp_wd = ahb3_hwdata_o;
          else if (ahb3_hwdata_o != dp_wd) stab_viol++;
        end
        dp_first = 0;
        if (dp_wait > 0) begin
          ahb3_hready_i = 1'b0;
          ahb3_hresp_i  = dp_err && (dp_wait == 1);
          dp_wait--;
        end else begin
          ahb3_hready_i = 1'b1;
          ahb3_hresp_i  = dp_err;
          if (!dp_write) ahb3_hrdata_i = rom(dp_addr);
          else if (!dp_err) ram[dp_addr] = ahb3_hwdata_o;
          dp_on = 0;
        end
      end else if (ahb3_htrans_o == 2'b10) begin
        if (!ap_on) begin
          ap_on = 1; ap_addr = ahb3_haddr_o; ap_write = ahb3_hwrite_o; ap_wait = cfg_aw;
          log_a.push_back(ahb3_haddr_o); log_w.push_back(ahb3_hwrite_o);
        end else if (ahb3_haddr_o != ap_addr || ahb3_hwrite_o != ap_write) begin
          stab_viol++;
        end
        ahb3_hresp_i = 1'b0;
        if (ap_wait > 0) begin
          ahb3_hready_i = 1'b0;
          ap_wait--;
        end else begin
          ahb3_hready_i = 1'b1;
          ap_on = 0; dp_on = 1; dp_first = 1;
          dp_addr = ap_addr; dp_write = ap_write;
          dp_err = ap_write ? (cfg_ek == 2 && wr_idx == cfg_ew) : (cfg_ek == 1 && rd_idx == cfg_ew);
          if (ap_write) wr_idx++; else rd_idx++;
          dp_wait = cfg_dw + (dp_err ? 1 : 0);
        end
      end else begin
        ahb3_hready_i = 1'b1;
        ahb3_hresp_i  = 1'b0;
      end
    end
  end

  // Copy model: per word read then write, each phase 1 cycle plus waits,
  // an error data phase lasts two extra cycles, then ERR and DONE.
  function automatic int model_cycles(input vec_t v);
    int full;
    full = 4 + 2 * v.aw + 2 * v.dw;
    if (v.len == 0) return 1;
    if (v.ek == 1) return v.ew * full + (1 + v.aw) + (v.dw + 2) + 2;
    if (v.ek == 2) return v.ew * full + 2 * (1 + v.aw) + (1 + v.dw) + (v.dw + 2) + 2;
    return v.len * full + 1;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    v.src = $urandom;
    v.dst = $urandom;
    v.len = int'($urandom_range(1, 5));
    v.aw  = int'($urandom_range(0, 1));
    v.dw  = int'($urandom_range(0, 2));
    v.ek  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
    v.ew  = int'($urandom_range(0, v.len - 1));
    v.mid = 1'($urandom_range(0, 1));
    v.exp_cyc = model_cycles(v);
    v.exp_err = (v.ek != 0);
    v.exp_nwr = (v.ek != 0) ? v.ew : v.len;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input bit prev_err, input int idx);
    int          cyc;
    int          busy_gaps;
    bit          seen;
    logic [31:0] as, ad;
    logic [31:0] exp_a [$];
    bit          exp_w [$];
    cfg_aw = v.aw; cfg_dw = v.dw; cfg_ek = v.ek; cfg_ew = v.ew;
    @(negedge clk);
    check($sformatf("v%0d err_sticky", idx), {63'd0, err_o}, {63'd0, prev_err});
    src_addr_i = v.src; dst_addr_i = v.dst; len_i = 16'(v.len); start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; cyc = 1; seen = 0; busy_gaps = 0;
    while (cyc < 2000) begin
      if (done_o) begin seen = 1; break; end
      if (!busy_o) busy_gaps++;
      if (v.mid && cyc == 3) begin
        start_i = 1'b1; src_addr_i = 32'hDEAD_0000; dst_addr_i = 32'hBEEF_0000; len_i = 16'd9;
      end else begin
        start_i = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    check($sformatf("v%0d done_seen", idx), {63'd0, seen}, 64'd1);
    check($sformatf("v%0d done_cycle", idx), 64'(cyc), 64'(v.exp_cyc));
    check($sformatf("v%0d busy_in_run", idx), 64'(busy_gaps), 64'd0);
    check($sformatf("v%0d err", idx), {63'd0, err_o}, {63'd0, v.exp_err});
    check($sformatf("v%0d busy_at_done", idx), {63'd0, busy_o}, 64'd1);
    if (v.mid) start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check($sformatf("v%0d done_pulse", idx), {63'd0, done_o}, 64'd0);
    check($sformatf("v%0d idle_after", idx), {62'd0, busy_o, ahb3_htrans_o != 2'b00}, 64'd0);
    check($sformatf("v%0d stable", idx), 64'(stab_viol), 64'd0);
    as = {v.src[31:2], 2'b00};
    ad = {v.dst[31:2], 2'b00};
    for (int i = 0; i < v.len; i++) begin
      exp_a.push_back(as + 32'(4 * i)); exp_w.push_back(1'b0);
      if (v.ek == 1 && v.ew == i) break;
      exp_a.push_back(ad + 32'(4 * i)); exp_w.push_back(1'b1);
      if (v.ek == 2 && v.ew == i) break;
    end
    check($sformatf("v%0d n_xfers", idx), 64'(log_a.size()), 64'(exp_a.size()));
    for (int i = 0; i < exp_a.size() && i < log_a.size(); i++)
      check($sformatf("v%0d xfer%0d", idx, i), {31'd0, log_w[i], log_a[i]}, {31'd0, exp_w[i], exp_a[i]});
    check($sformatf("v%0d n_written", idx), 64'(ram.size()), 64'(v.exp_nwr));
    for (int i = 0; i < v.exp_nwr; i++) begin
      logic [31:0] got;
      got = ram.exists(ad + 32'(4 * i)) ? ram[ad + 32'(4 * i)] : 32'hxxxx_xxxx;
      check($sformatf("v%0d ram%0d", idx, i), {32'd0, got}, {32'd0, rom(as + 32'(4 * i))});
    end
  endtask

  vec_t tbl [8];

  initial begin
    bit   prev_err;
    int   n;
    vec_t v;
    tbl[0] = '{32'h0000_0000, 32'h0001_0000, 3, 0, 0, 0, 0, 1'b0, 13, 1'b0, 3};
    tbl[1] = '{32'h0000_0040, 32'h0001_0040, 2, 0, 2, 0, 0, 1'b0, 17, 1'b0, 2};
    tbl[2] = '{32'h0000_0080, 32'h0001_0080, 3, 0, 0, 1, 1, 1'b0,  9, 1'b1, 1};
    tbl[3] = '{32'h0000_0100, 32'h0001_0100, 0, 0, 0, 0, 0, 1'b0,  1, 1'b0, 0};
    tbl[4] = '{32'hFFFF_FFFF, 32'h0000_2003, 2, 0, 0, 0, 0, 1'b0,  9, 1'b0, 2};
    tbl[5] = '{32'h0000_0100, 32'h0000_3000, 4, 0, 0, 0, 0, 1'b1, 17, 1'b0, 4};
    tbl[6] = '{32'h0000_0200, 32'h0000_4000, 2, 1, 1, 2, 0, 1'b0, 11, 1'b1, 0};
    tbl[7] = '{32'h0000_0300, 32'h0000_5000, 1, 2, 0, 0, 0, 1'b0,  9, 1'b0, 1};

    rst = 1'b0; start_i = 1'b0; src_addr_i = '0; dst_addr_i = '0; len_i = '0;
    repeat (3) @(negedge clk);
    check("rst busy/done/err", {61'd0, busy_o, done_o, err_o}, 64'd0);
    check("rst htrans", 64'(ahb3_htrans_o), 64'd0);
    check("rst haddr/hwrite", {31'd0, ahb3_hwrite_o, ahb3_haddr_o}, 64'd0);
    check("rst hwdata", 64'(ahb3_hwdata_o), 64'd0);
    check("const hsize/hburst/hprot/hmastlock",
          {51'd0, ahb3_hsize_o, ahb3_hburst_o, ahb3_hprot_o, 1'b0, ahb3_hmastlock_o},
          {51'd0, 3'd2, 3'd0, 4'b0011, 1'b0, 1'b0});
    rst = 1'b1;
    @(negedge clk);

    prev_err = 1'b0;
    for (int i = 0; i < 8; i++) begin
      run_vec(tbl[i], prev_err, i);
      prev_err = tbl[i].exp_err;
    end

    // asynchronous reset while the write data phase is stalled
    cfg_aw = 0; cfg_dw = 3; cfg_ek = 0; cfg_ew = 0;
    src_addr_i = 32'h40; dst_addr_i = 32'h6000; len_i = 16'd3; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    n = 0;
    while (!(ahb3_htrans_o == 2'b10 && ahb3_hwrite_o) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rstmid reached WR_A", 64'(n < 100), 64'd1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("rstmid htrans", 64'(ahb3_htrans_o), 64'd0);
    check("rstmid haddr/hwrite", {31'd0, ahb3_hwrite_o, ahb3_haddr_o}, 64'd0);
    check("rstmid busy/done/err", {61'd0, busy_o, done_o, err_o}, 64'd0);
    check("rstmid hwdata", 64'(ahb3_hwdata_o), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("after rst idle", {61'd0, busy_o, err_o, ahb3_htrans_o != 2'b00}, 64'd0);
    run_vec(tbl[0], 1'b0, 100);

    prev_err = 1'b0;
    for (int i = 0; i < 8; i++) begin
      v = rand_vec();
      run_vec(v, prev_err, 200 + i);
      prev_err = v.exp_err;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
